// File: rtl/raw_readout.sv
// Reader side of the raw hit memory: fetches one event window bin by bin and
// streams it as OW-bit words framed by a header and a trailer.
module raw_readout #(
  parameter int DW = 672,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ev_valid,
  input  logic [7:0]    ev_addr,
  output logic          ev_ready,
  input  logic [7:0]    wblock,
  output logic [7:0]    adr,
  input  logic [DW-1:0] dr,
  output logic [7:0]    adb,
  output logic [OW-1:0] ro_data,
  output logic          ro_valid,
  input  logic          ro_ready,
  output logic          ro_last,
  output logic          busy
);

  localparam int NW = DW / OW;
  localparam int WW = $clog2(NW);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, LOAD, SHIFT, TRL} state_e;

  state_e        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    nbins_q, nbins_d;
  logic [7:0]    bin_q, bin_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    adb_q, adb_d;
  logic [WW-1:0] word_q, word_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [OW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic [13:0]   wcount;
  logic [OW-1:0] trailer;
  logic          hs;

  assign wcount  = 14'(nbins_q) * 14'(NW);
  assign trailer = OW'({2'b11, wcount});
  assign hs      = valid_q & ro_ready;

  // Output words are registered, so every transition that presents a new word
  // loads data_d/valid_d on the same edge that enters the presenting state.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    nbins_d = nbins_q;
    bin_d   = bin_q;
    adr_d   = adr_q;
    adb_d   = adb_q;
    word_d  = word_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (ev_valid) begin
          base_d  = ev_addr;
          nbins_d = wblock;
          bin_d   = '0;
          word_d  = '0;
          data_d  = OW'({4'hA, 4'h0, wblock});
          valid_d = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          if (nbins_q == 8'd0) begin
            data_d  = trailer;
            last_d  = 1'b1;
            state_d = TRL;
          end else begin
            valid_d = 1'b0;
            adr_d   = base_q + bin_q;
            state_d = ADDR;
          end
        end
      end
      ADDR: state_d = LOAD;
      LOAD: begin
        sr_d    = dr;
        data_d  = dr[OW-1:0];
        valid_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (hs) begin
          sr_d   = sr_q >> OW;
          data_d = sr_q[2*OW-1:OW];
          word_d = word_q + WW'(1);
          if (word_q == WW'(NW - 1)) begin
            word_d = '0;
            if (bin_q + 8'd1 == nbins_q) begin
              data_d  = trailer;
              last_d  = 1'b1;
              state_d = TRL;
            end else begin
              valid_d = 1'b0;
              bin_d   = bin_q + 8'd1;
              adr_d   = base_q + bin_q + 8'd1;
              state_d = ADDR;
            end
          end
        end
      end
      TRL: begin
        if (hs) begin
          adb_d   = base_q + nbins_q;
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      nbins_q <= '0;
      bin_q   <= '0;
      adr_q   <= '0;
      adb_q   <= '0;
      word_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      nbins_q <= nbins_d;
      bin_q   <= bin_d;
      adr_q   <= adr_d;
      adb_q   <= adb_d;
      word_q  <= word_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign ev_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign adr      = adr_q;
  assign adb      = adb_q;
  assign ro_data  = data_q;
  assign ro_valid = valid_q;
  assign ro_last  = last_q;

endmodule

// File: tb/tb_raw_readout.sv
// Self-checking bench for raw_readout: a registered-read memory model feeds the
// DUT and each frame is compared against a word list derived from memory contents.
module tb_raw_readout;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ev_valid;
  logic [7:0]   ev_addr;
  logic         ev_ready;
  logic [7:0]   wblock;
  logic [7:0]   adr;
  logic [671:0] dr;
  logic [7:0]   adb;
  logic [15:0]  ro_data;
  logic         ro_valid;
  logic         ro_ready;
  logic         ro_last;
  logic         busy;

  raw_readout dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_addr(ev_addr),
    .ev_ready(ev_ready), .wblock(wblock), .adr(adr), .dr(dr), .adb(adb),
    .ro_data(ro_data), .ro_valid(ro_valid), .ro_ready(ro_ready),
    .ro_last(ro_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [671:0] mem [256];
  always @(posedge clk) dr <= mem[adr];

  int checks = 0;
  int failures = 0;

  logic [15:0] obsQ[$];
  logic [15:0] expQ[$];
  logic [7:0]  adrQ[$];
  int          holdErr, evReadyErr, trlCyc, accCyc;
  bit          timedOut;
  logic        validAfter;

  function automatic void fill_pattern(input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 42; k++)
        mem[8'(base + b)][k*16 +: 16] = {8'(b), 8'(k)};
  endfunction

  function automatic void fill_random();
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 21; k++)
        mem[a][k*32 +: 32] = $urandom();
  endfunction

  // Frame = header, every bin of the window low word first, trailer with word count.
  function automatic void build_expected(input logic [7:0] base, input int n);
    expQ.delete();
    expQ.push_back({8'hA0, 8'(n)});
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 42; k++)
        expQ.push_back(mem[8'(base + b)][k*16 +: 16]);
    expQ.push_back({2'b11, 14'(n * 42)});
  endfunction

  task automatic start_event(input logic [7:0] base, input logic [7:0] n, input bit hold);
    @(negedge clk);
    ev_valid = 1'b1;
    ev_addr  = base;
    wblock   = n;
    accCyc   = cyc;
    @(negedge clk);
    if (!hold) ev_valid = 1'b0;
  endtask

  // Observes one frame from the current negedge until the cycle after the trailer handshake.
  task automatic collect_frame(input int readyPct, input int budget);
    logic [15:0] pData;
    logic        pLast;
    logic [7:0]  pAdr, pAdb, lastAdr;
    bit          stall, done;
    int          n;
    obsQ.delete(); adrQ.delete();
    holdErr = 0; evReadyErr = 0; timedOut = 0;
    stall = 0; done = 0; n = 0;
    pData = '0; pLast = 0; pAdr = adr; pAdb = adb;
    lastAdr = adr;
    while (!done) begin
      if (n >= budget) begin
        timedOut = 1;
        break;
      end
      if (stall && (ro_valid !== 1'b1 || ro_data !== pData || ro_last !== pLast ||
                    adr !== pAdr || adb !== pAdb))
        holdErr++;
      if (adr !== lastAdr) begin
        adrQ.push_back(adr);
        lastAdr = adr;
      end
      if (ev_ready) evReadyErr++;
      ro_ready = ($urandom_range(99) < readyPct);
      if (ro_valid && ro_ready) begin
        obsQ.push_back(ro_data);
        if (ro_last) begin
          done = 1;
          trlCyc = cyc;
        end
        stall = 0;
      end else begin
        stall = ro_valid;
        pData = ro_data; pLast = ro_last; pAdr = adr; pAdb = adb;
      end
      @(negedge clk);
      n++;
    end
    ro_ready = 1'b0;
    validAfter = ro_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ro_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ro_valid got=%b want=0", ro_valid); end
    checks++; if (ro_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_ro_last got=%b want=0", ro_last); end
    checks++; if (ro_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_ro_data got=%h want=0000", ro_data); end
    checks++; if (adr !== 8'h0) begin failures++; $display("[TB] FAIL reset_adr got=%h want=00", adr); end
    checks++; if (adb !== 8'h0) begin failures++; $display("[TB] FAIL reset_adb got=%h want=00", adb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ev_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ev_ready got=%b want=1", ev_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    fill_random();
    fill_pattern(8'h10, 2);
    build_expected(8'h10, 2);
    start_event(8'h10, 8'd2, 0);
    collect_frame(100, 1000);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut) begin failures++; $display("[TB] FAIL basic_timeout got=1 want=0"); end
    checks++; if (bad >= 0 || obsQ.size() != expQ.size()) begin failures++;
      $display("[TB] FAIL basic_seq idx=%0d got_len=%0d want_len=%0d", bad, obsQ.size(), expQ.size()); end
    checks++; if (obsQ.size() == 86 && obsQ[85] !== 16'hC054) begin failures++; $display("[TB] FAIL basic_trailer got=%h want=c054", obsQ[85]); end
    checks++; if (adrQ.size() != 2 || adrQ[0] !== 8'h10 || adrQ[1] !== 8'h11) begin failures++;
      $display("[TB] FAIL basic_adr got_n=%0d first=%h want 10,11", adrQ.size(), adrQ.size() > 0 ? adrQ[0] : 8'hxx); end
    checks++; if (adb !== 8'h12) begin failures++; $display("[TB] FAIL basic_adb got=%h want=12", adb); end
    // Latency counts the accept cycle through the first idle cycle after the trailer.
    checks++; if (trlCyc - accCyc + 2 != 92) begin failures++; $display("[TB] FAIL basic_latency got=%0d want=92", trlCyc - accCyc + 2); end
    checks++; if (validAfter !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_drop got=%b want=0", validAfter); end
  endtask

  task automatic test_wrap();
    int bad;
    fill_random();
    build_expected(8'hFE, 3);
    start_event(8'hFE, 8'd3, 0);
    collect_frame(100, 1000);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut || bad >= 0 || obsQ.size() != expQ.size()) begin failures++;
      $display("[TB] FAIL wrap_seq idx=%0d got_len=%0d want_len=%0d timeout=%0d", bad, obsQ.size(), expQ.size(), timedOut); end
    checks++; if (obsQ.size() > 0 && obsQ[obsQ.size()-1] !== 16'hC07E) begin failures++;
      $display("[TB] FAIL wrap_trailer got=%h want=c07e", obsQ[obsQ.size()-1]); end
    checks++; if (adrQ.size() != 3 || adrQ[0] !== 8'hFE || adrQ[1] !== 8'hFF || adrQ[2] !== 8'h00) begin failures++;
      $display("[TB] FAIL wrap_adr got_n=%0d want fe,ff,00", adrQ.size()); end
    checks++; if (adb !== 8'h01) begin failures++; $display("[TB] FAIL wrap_adb got=%h want=01", adb); end
  endtask

  task automatic test_empty();
    logic [7:0] adrBefore;
    adrBefore = adr;
    start_event(8'h40, 8'd0, 0);
    collect_frame(100, 100);
    checks++; if (timedOut || obsQ.size() != 2 || obsQ[0] !== 16'hA000 || obsQ[1] !== 16'hC000) begin failures++;
      $display("[TB] FAIL empty_seq got_len=%0d want A000,C000 timeout=%0d", obsQ.size(), timedOut); end
    checks++; if (adr !== adrBefore || adrQ.size() != 0) begin failures++; $display("[TB] FAIL empty_adr got=%h want=%h", adr, adrBefore); end
    checks++; if (adb !== 8'h40) begin failures++; $display("[TB] FAIL empty_adb got=%h want=40", adb); end
    checks++; if (trlCyc - accCyc + 2 != 4) begin failures++; $display("[TB] FAIL empty_latency got=%0d want=4", trlCyc - accCyc + 2); end
  endtask

  task automatic test_backpressure();
    int bad;
    fill_random();
    fill_pattern(8'h10, 2);
    build_expected(8'h10, 2);
    start_event(8'h10, 8'd2, 0);
    collect_frame(30, 5000);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut || bad >= 0 || obsQ.size() != 86) begin failures++;
      $display("[TB] FAIL bp_seq idx=%0d got_len=%0d want_len=86 timeout=%0d", bad, obsQ.size(), timedOut); end
    checks++; if (holdErr != 0) begin failures++; $display("[TB] FAIL bp_hold unstable_cycles=%0d want=0", holdErr); end
    checks++; if (adb !== 8'h12) begin failures++; $display("[TB] FAIL bp_adb got=%h want=12", adb); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2, n1, n2;
    int bad;
    fill_random();
    b1 = 8'($urandom); b2 = 8'($urandom);
    n1 = 8'($urandom_range(1, 2)); n2 = 8'd3 - n1;
    build_expected(b1, int'(n1));
    start_event(b1, n1, 1);
    ev_addr = b2;
    wblock  = n2;
    collect_frame(100, 1000);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut || bad >= 0 || obsQ.size() != expQ.size()) begin failures++;
      $display("[TB] FAIL b2b_first_seq idx=%0d got_len=%0d want_len=%0d", bad, obsQ.size(), expQ.size()); end
    checks++; if (evReadyErr != 0) begin failures++; $display("[TB] FAIL b2b_ev_ready busy_cycles_ready=%0d want=0", evReadyErr); end
    checks++; if (ev_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_reaccept got=%b want=1", ev_ready); end
    build_expected(b2, int'(n2));
    @(negedge clk);
    ev_valid = 1'b0;
    checks++; if (ro_valid !== 1'b1 || ro_data !== expQ[0]) begin failures++;
      $display("[TB] FAIL b2b_header got=%h/%b want=%h/1", ro_data, ro_valid, expQ[0]); end
    collect_frame(100, 1000);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut || bad >= 0 || obsQ.size() != expQ.size()) begin failures++;
      $display("[TB] FAIL b2b_second_seq idx=%0d got_len=%0d want_len=%0d", bad, obsQ.size(), expQ.size()); end
    checks++; if (adb !== 8'(b2 + n2)) begin failures++; $display("[TB] FAIL b2b_adb got=%h want=%h", adb, 8'(b2 + n2)); end
  endtask

  task automatic test_reset_mid();
    int hsCount, bad;
    fill_random();
    start_event(8'h20, 8'd2, 0);
    ro_ready = 1'b1;
    hsCount = 0;
    for (int i = 0; i < 300 && hsCount < 50; i++) begin
      if (ro_valid && ro_ready) hsCount++;
      if (hsCount < 50) @(negedge clk);
    end
    checks++; if (hsCount != 50) begin failures++; $display("[TB] FAIL rstmid_reach got=%0d want=50", hsCount); end
    rst_n = 1'b0;
    ro_ready = 1'b0;
    @(negedge clk);
    checks++; if (ro_valid !== 1'b0 || adb !== 8'h0 || adr !== 8'h0 || busy !== 1'b0) begin failures++;
      $display("[TB] FAIL rstmid_state got valid=%b adb=%h adr=%h busy=%b want 0,00,00,0", ro_valid, adb, adr, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    build_expected(8'h33, 1);
    start_event(8'h33, 8'd1, 0);
    collect_frame(100, 500);
    bad = -1;
    foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
    checks++; if (timedOut || bad >= 0 || obsQ.size() != expQ.size()) begin failures++;
      $display("[TB] FAIL rstmid_after_seq idx=%0d got_len=%0d want_len=%0d", bad, obsQ.size(), expQ.size()); end
    checks++; if (adb !== 8'h34) begin failures++; $display("[TB] FAIL rstmid_adb got=%h want=34", adb); end
  endtask

  task automatic test_random();
    logic [7:0] b, n;
    int pct, bad;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      b = 8'($urandom); n = 8'($urandom_range(0, 3));
      pct = $urandom_range(20, 100);
      build_expected(b, int'(n));
      start_event(b, n, 0);
      collect_frame(pct, 5000);
      bad = -1;
      foreach (expQ[i]) if (bad < 0 && (i >= obsQ.size() || obsQ[i] !== expQ[i])) bad = i;
      checks++; if (timedOut || bad >= 0 || obsQ.size() != expQ.size() || holdErr != 0) begin failures++;
        $display("[TB] FAIL rand_seq it=%0d idx=%0d got_len=%0d want_len=%0d hold=%0d", it, bad, obsQ.size(), expQ.size(), holdErr); end
      checks++; if (adb !== 8'(b + n)) begin failures++; $display("[TB] FAIL rand_adb it=%0d got=%h want=%h", it, adb, 8'(b + n)); end
    end
  endtask

  initial begin
    ev_valid = 1'b0; ev_addr = '0; wblock = '0; ro_ready = 1'b0;
    fill_random();
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/raw_readout.md
# raw_readout

Reader side of the raw hit memory. Takes one queued event (start address of its time window), reads `wblock` consecutive 672-bit time bins from the memory through the memory's registered-address read port, and serializes each bin into 16-bit words on a valid/ready stream. Each event is framed by a header and a trailer. After an event is fully sent, the block advances the memory's `adb` (oldest-unreleased) pointer so the writer can reuse that space.

## Interface
Parameters:
- `DW`, 672, raw memory word width; must be a multiple of `OW`.
- `OW`, 16, output word width.
- `NW`, `DW/OW` (42), output words per time bin; derived, not overridden.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ev_valid`  in  1  event request pending.
- `ev_addr`  in  8  memory address of the event's first time bin.
- `ev_ready`  out  1  event accepted on a cycle where `ev_valid & ev_ready`.
- `wblock`  in  8  bins per event; sampled at event acceptance.
- `adr`  out  8  memory read address, registered.
- `dr`  in  DW  memory read data; valid the cycle after `adr` is sampled.
- `adb`  out  8  release pointer to memory, registered.
- `ro_data`  out  OW  output word, registered.
- `ro_valid`  out  1  `ro_data` valid.
- `ro_ready`  in  1  downstream accepts `ro_data` on `ro_valid & ro_ready`.
- `ro_last`  out  1  marks the trailer word.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, HDR, ADDR, LOAD, SHIFT, TRL.
- **IDLE**: `ev_ready = 1`, combinational from the state.
  - On accept, latch `base = ev_addr` and `nbins = wblock`, clear `bin` and `word`, then go to HDR.
- **HDR**: present `ro_data = {4'hA, 4'h0, nbins}` with `ro_valid` high.
  - On handshake, go to TRL if `nbins == 0`; otherwise load `adr <= base + bin` and go to ADDR.
- **ADDR**: one cycle. The memory samples `adr` at the end of this cycle. Go to LOAD.
- **LOAD**: one cycle. Capture `dr` into a DW-bit shift register and go to SHIFT.
- **SHIFT**: `ro_data` is the low OW bits of the shift register.
  - On each handshake, shift right by OW and increment `word`.
  - On the handshake of word NW-1:
    - if `bin + 1 == nbins`, go to TRL;
    - otherwise increment `bin`, load `adr <= base + bin + 1`, and go to ADDR.
- **TRL**: present `ro_data = {2'b11, wcount[13:0]}` with `ro_last = 1`, where `wcount = nbins*NW`. Maximum is 255*42 = 10710, which fits in 14 bits.
  - On handshake: `adb <= base + nbins` (mod 256), drop `ro_valid`/`ro_last`, and go to IDLE.
- Address arithmetic is 8-bit and wraps modulo 256, with no special case at 0xFF→0x00.
- `wblock` and `ev_addr` changes while busy are ignored. `ev_valid` while busy waits in place; the block drops no events.

## Timing
- Reset values: IDLE, `adr = 0`, `adb = 0`, `ro_data = 0`, `ro_valid = 0`, `ro_last = 0`, `busy = 0`, `ev_ready = 1`.
- Event accept to header valid: 1 cycle.
- Per bin, with `ro_ready` held high: 2 cycles (ADDR, LOAD) plus NW cycles of SHIFT, i.e. 44 cycles.
- Event latency: `3 + 44*nbins + 1` cycles from accept to trailer accepted.
- Stream rules:
  - `ro_data`, `ro_valid` and `ro_last` are stable from assertion until the handshake.
  - `ro_valid` is never retracted without a handshake.
  - `ro_valid` is low in ADDR, LOAD and IDLE.
- `ro_ready` low stalls indefinitely. No memory read or pointer change occurs while stalled.
- `adb` changes only on the trailer handshake, exactly once per event. The memory's `full` computation therefore keeps the whole window protected until readout completes.
- Reset mid-event: immediate return to IDLE with all reset values. The partial frame is abandoned, with no trailer. The writer side must be reset together with this block.

## Test plan
- Event `ev_addr = 0x10`, `wblock = 2`, memory bins filled so word k of bin b equals `{b[7:0], k[7:0]}`, `ro_ready` = 1 → `ro_data` sequence:
  - header 0xA002;
  - 0x0000..0x0029, then 0x0100..0x0129;
  - trailer 0xC054 with `ro_last`;
  - `adr` takes values 0x10, 0x11; `adb` becomes 0x12.
  - The frame ends 92 cycles after accept.
- Wrap: `ev_addr = 0xFE`, `wblock = 3` → `adr` sequence 0xFE, 0xFF, 0x00; trailer 0xC07E; `adb` = 0x01.
- Empty window: `wblock = 0`, `ev_addr = 0x40` → header 0xA000, then trailer 0xC000; `adr` unchanged; `adb` = 0x40.
- Backpressure: same event as scenario 1 with `ro_ready` random at 30% high → identical 86-word sequence; no duplicate or dropped word; outputs held stable while `ro_ready` is low.
- Back-to-back: second `ev_valid` held during the first event → `ev_ready` stays low until IDLE; second header appears 1 cycle after re-accept; `wblock` changed mid-event does not affect the first frame.
- Reset: assert `rst_n` low during SHIFT of bin 1 → next cycle `ro_valid = 0`, `adb = 0`, `adr = 0`, `busy = 0`; a new event after release reads out cleanly.
